// File: rtl/logical_unit_mc.sv
// Multi-cycle logical unit: single-cycle bitwise ops plus iterative CPOP/CLZ,
// with valid/ready handshakes on both sides and a synchronous flush.
module logical_unit_mc #(
   parameter int unsigned size  = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [size-1:0] A,
   input  logic [size-1:0] B,
   input  logic [2:0]      Sel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [size-1:0] S,
   output logic            busy
);

   localparam int unsigned N    = size / CHUNK;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned AccW = $clog2(size + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic [size-1:0]   a_q, a_d;
   logic              clz_q, clz_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [AccW-1:0]   acc_q, acc_d;
   logic              seen_q, seen_d;
   logic [size-1:0]   s_q, s_d;

   logic              accept;
   logic [CHUNK-1:0]  slice;
   logic [AccW-1:0]   slice_pop, slice_lz;
   logic              slice_hit;
   logic [AccW-1:0]   acc_step;
   logic              seen_step;
   logic [size-1:0]   bitwise;

   assign in_ready  = (state_q == StIdle) & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign S         = s_q;

   // The operand register shifts left each cycle, so the top slice is always the current one.
   assign slice = a_q[size-1 -: CHUNK];

   always_comb begin
      slice_pop = '0;
      slice_lz  = '0;
      slice_hit = 1'b0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         slice_pop = slice_pop + AccW'(slice[i]);
         if (slice[i]) begin
            slice_hit = 1'b1;
         end else if (!slice_hit) begin
            slice_lz = slice_lz + AccW'(1);
         end
      end
   end

   always_comb begin
      acc_step  = acc_q;
      seen_step = seen_q;
      if (clz_q) begin
         if (!seen_q) begin
            acc_step  = acc_q + slice_lz;
            seen_step = |slice;
         end
      end else begin
         acc_step = acc_q + slice_pop;
      end
   end

   always_comb begin
      bitwise = '0;
      unique case (Sel)
         3'd0:    bitwise = A ^ B;
         3'd1:    bitwise = A | B;
         3'd2:    bitwise = A & B;
         3'd4:    bitwise = ~(A ^ B);
         3'd5:    bitwise = A & ~B;
         default: bitwise = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      clz_d   = clz_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      seen_d  = seen_q;
      s_d     = s_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (Sel[2:1] == 2'b11) begin
                  a_d     = A;
                  clz_d   = Sel[0];
                  cnt_d   = '0;
                  acc_d   = '0;
                  seen_d  = 1'b0;
                  state_d = StBusy;
               end else begin
                  s_d     = bitwise;
                  state_d = StDone;
               end
            end
         end
         StBusy: begin
            a_d    = a_q << CHUNK;
            acc_d  = acc_step;
            seen_d = seen_step;
            cnt_d  = cnt_q + CntW'(1);
            // Last slice: publish the final count on the same edge.
            if (cnt_q == CntW'(N - 1)) begin
               cnt_d   = '0;
               s_d     = {{(size - AccW){1'b0}}, acc_step};
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
         s_d     = '0;
         cnt_d   = '0;
         acc_d   = '0;
         seen_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         clz_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         seen_q  <= 1'b0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         clz_q   <= clz_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         seen_q  <= seen_d;
         s_q     <= s_d;
      end
   end

endmodule

// File: tb/tb_logical_unit_mc.sv
// Scoreboard bench for logical_unit_mc: the driver queues expected results and
// latencies, a negedge monitor checks each result as out_valid rises.
module tb_logical_unit_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  Sel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] S;
   logic        busy;

   typedef struct {
      logic [31:0] s;
      int unsigned lat;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   logical_unit_mc #(.size(32), .CHUNK(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Sel       (Sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Monitor: one expected entry per rising out_valid.
   initial begin
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid && !prev_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output actual S=%h required no output", S);
               end else begin
                  e = sb.pop_front();
                  checks++;
                  if (S !== e.s) begin
                     errors++;
                     $display("FAIL result actual=%h required=%h", S, e.s);
                  end
                  checks++;
                  if (cyc - e.cyc != e.lat) begin
                     errors++;
                     $display("FAIL latency actual=%0d required=%0d", cyc - e.cyc, e.lat);
                  end
               end
            end
            prev_valid = out_valid;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                        input bit push, input logic [31:0] exp, input int unsigned lat);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout actual in_ready=0 required in_ready=1");
      end
      A        = a;
      B        = b;
      Sel      = sel;
      in_valid = 1'b1;
      if (push) sb.push_back('{exp, lat, cyc});
      @(negedge clk);
      in_valid = 1'b0;
      A        = $urandom;
      B        = $urandom;
      Sel      = 3'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || out_valid) && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (busy || out_valid) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual busy=%b out_valid=%b required 0 0", busy, out_valid);
      end
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      B         = '0;
      Sel       = '0;
      repeat (2) @(negedge clk);
      chk("rst_S", S, 32'h0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
      reset = 1'b1;

      // Bitwise ops, including ZERO
      issue(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd0, 1, 32'hFF00_0FF0, 1);
      issue(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd1, 1, 32'hFFF0_0FFF, 1);
      issue(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd2, 1, 32'h00F0_000F, 1);
      issue(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd4, 1, 32'h00FF_F00F, 1);
      issue(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd5, 1, 32'hF000_00F0, 1);
      issue(32'hFFFF_FFFF, 32'h1234_5678, 3'd3, 1, 32'h0000_0000, 1);
      issue(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd0, 1, 32'hFF00_0FF0, 1);
      wait_idle();

      // Async reset while a CPOP is in flight
      issue(32'hFFFF_FFFF, 32'h0, 3'd6, 0, 32'h0, 0);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst_S", S, 32'h0);
      chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("midrst_busy", {31'b0, busy}, 32'h0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'h1);
      @(negedge clk);
      reset = 1'b1;

      // CPOP
      issue(32'hFFFF_FFFF, 32'h0, 3'd6, 1, 32'd32, 5);
      issue(32'h0000_0000, 32'hFFFF_FFFF, 3'd6, 1, 32'd0, 5);
      issue(32'hF0F0_00FF, 32'h0, 3'd6, 1, 32'd16, 5);
      // CLZ
      issue(32'h0000_0001, 32'h0, 3'd7, 1, 32'd31, 5);
      issue(32'h8000_0000, 32'h0, 3'd7, 1, 32'd0, 5);
      issue(32'h0001_0000, 32'h0, 3'd7, 1, 32'd15, 5);
      issue(32'h0000_0000, 32'h0, 3'd7, 1, 32'd32, 5);
      wait_idle();

      // Back-pressure: result must hold while out_ready is low
      out_ready = 1'b0;
      issue(32'h0000_00F0, 32'h0, 3'd7, 1, 32'd24, 5);
      begin
         int n = 0;
         while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         chk("hold_S", S, 32'd24);
         chk("hold_out_valid", {31'b0, out_valid}, 32'h1);
         chk("hold_in_ready", {31'b0, in_ready}, 32'h0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_out_valid", {31'b0, out_valid}, 32'h0);
      chk("release_busy", {31'b0, busy}, 32'h0);
      chk("release_in_ready", {31'b0, in_ready}, 32'h1);

      // Flush in the 2nd BUSY cycle with a competing in_valid
      issue(32'hFFFF_FFFF, 32'h0, 3'd6, 0, 32'h0, 0);
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      A        = 32'h1234_5678;
      B        = 32'h0F0F_0F0F;
      Sel      = 3'd1;
      #1;
      chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'h0);
      chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
      chk("flush_S", S, 32'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("flush_no_result", {31'b0, out_valid}, 32'h0);
      end
      issue(32'h0001_0000, 32'h0, 3'd7, 1, 32'd15, 5);
      wait_idle();

      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
